// File: rtl/dram_cim_pkg.sv
// Shared types, widths and a byte-select helper for the DRAM core read responder.
package dram_cim_pkg;

  localparam int ROW_W     = 6;
  localparam int DEMUX_W   = 3;
  localparam int ADDR_BITS = 9;
  localparam int ROW_BITS  = 64;
  localparam int BYTE_W    = 8;
  localparam int ROWS      = 1 << ROW_W;

  typedef enum logic [2:0] {IDLE, ADDR, ARMED, SENSE, SHIFT} state_e;

  function automatic logic [BYTE_W-1:0] sel_byte(input logic [ROW_BITS-1:0] row,
                                                 input logic [DEMUX_W-1:0]  k);
    return row[32'(k) * BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/dram_core_responder_if.sv
// Serial address / read-data / preload bundle between a controller and the responder.
interface dram_core_responder_if;
  import dram_cim_pkg::*;

  logic                RAD;
  logic                ADVLD;
  logic                RDEN;
  logic                VSAEN;
  logic                ROUT;
  logic                rout_vld;
  logic                rd_done;
  logic                addr_err;
  logic                pl_wen;
  logic [ROW_W-1:0]    pl_row;
  logic [ROW_BITS-1:0] pl_data;

  modport master (
    output RAD, ADVLD, RDEN, VSAEN, pl_wen, pl_row, pl_data,
    input  ROUT, rout_vld, rd_done, addr_err
  );

  modport slave (
    input  RAD, ADVLD, RDEN, VSAEN, pl_wen, pl_row, pl_data,
    output ROUT, rout_vld, rd_done, addr_err
  );

endinterface

// File: rtl/dram_row_array.sv
// 64 x 64-bit row storage: synchronous write, combinational read, contents never reset.
module dram_row_array
  import dram_cim_pkg::*;
(
  input  logic                CLK,
  input  logic                i_wen,
  input  logic [ROW_W-1:0]    i_wrow,
  input  logic [ROW_BITS-1:0] i_wdata,
  input  logic [ROW_W-1:0]    i_rrow,
  output logic [ROW_BITS-1:0] o_rdata
);

  logic [ROW_BITS-1:0] r_mem [ROWS];

  always_ff @(posedge CLK) begin
    if (i_wen) r_mem[i_wrow] <= i_wdata;
  end

  // Read sees pre-edge contents, so a same-edge latch returns the old row.
  assign o_rdata = r_mem[i_rrow];

endmodule

// File: rtl/dram_core_responder.sv
// DRAM core read responder: serial address in, sensed byte serialised out on ROUT.
// Optional DRAM_RESP_PARITY_EN appends an odd-parity bit as a 9th shifted bit.
module dram_core_responder
  import dram_cim_pkg::*;
#(
  parameter int unsigned SENSE_LAT = 2,
  parameter logic        ROUT_IDLE = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  dram_core_responder_if.slave  bus
);

`ifdef DRAM_RESP_PARITY_EN
  localparam int SH_W = BYTE_W + 1;
`else
  localparam int SH_W = BYTE_W;
`endif

  state_e               r_state, w_state_nxt;
  logic [ADDR_BITS-1:0] r_addr;
  logic [3:0]           r_bitcnt;
  logic                 r_err;
  logic [3:0]           r_cnt;
  logic [SH_W-1:0]      r_shift;
  logic [3:0]           r_shcnt;
  logic                 r_rd_done, r_addr_err;
  logic                 w_err_set, w_done_set, w_latch;
  logic [ROW_BITS-1:0]  w_row_data;
  logic [BYTE_W-1:0]    w_byte;
  logic                 w_rout, w_rout_vld;

  dram_row_array u_rows (
    .CLK     (CLK),
    .i_wen   (bus.pl_wen),
    .i_wrow  (bus.pl_row),
    .i_wdata (bus.pl_data),
    .i_rrow  (r_addr[ADDR_BITS-1 -: ROW_W]),
    .o_rdata (w_row_data)
  );

  assign w_byte = sel_byte(w_row_data, r_addr[DEMUX_W-1:0]);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = 1'b0;
    w_done_set  = 1'b0;
    w_latch     = 1'b0;
    unique case (r_state)
      IDLE:  if (bus.ADVLD) w_state_nxt = ADDR;
      ADDR: begin
        if (!bus.ADVLD) begin
          if (r_bitcnt == 4'(ADDR_BITS) && !r_err) begin
            w_state_nxt = ARMED;
          end else begin
            w_state_nxt = IDLE;
            w_err_set   = 1'b1;
          end
        end
      end
      ARMED: begin
        if (bus.RDEN)       w_state_nxt = SENSE;
        else if (bus.ADVLD) w_state_nxt = ADDR;
      end
      SENSE: begin
        if (r_cnt == 4'd0) begin
          if (bus.VSAEN) begin
            w_state_nxt = SHIFT;
            w_latch     = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_err_set   = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (r_shcnt == 4'(SH_W - 1)) begin
          w_state_nxt = IDLE;
          w_done_set  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_addr     <= '0;
      r_bitcnt   <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_shcnt    <= '0;
      r_rd_done  <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_rd_done  <= w_done_set;
      r_addr_err <= w_err_set;
      if ((r_state == IDLE || r_state == ARMED) && w_state_nxt == ADDR) begin
        r_addr   <= {{(ADDR_BITS-1){1'b0}}, bus.RAD};
        r_bitcnt <= 4'd1;
        r_err    <= 1'b0;
      end else if (r_state == ARMED && w_state_nxt == SENSE) begin
        r_cnt <= 4'(SENSE_LAT);
      end else if (r_state == ADDR && bus.ADVLD) begin
        r_addr <= {r_addr[ADDR_BITS-2:0], bus.RAD};
        if (r_bitcnt != 4'hF)             r_bitcnt <= r_bitcnt + 4'd1;
        if (r_bitcnt >= 4'(ADDR_BITS))    r_err    <= 1'b1;
      end else if (r_state == SENSE) begin
        if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        if (w_latch) begin
`ifdef DRAM_RESP_PARITY_EN
          r_shift <= {w_byte, ~^w_byte};
`else
          r_shift <= w_byte;
`endif
          r_shcnt <= '0;
        end
      end else if (r_state == SHIFT) begin
        r_shift <= r_shift << 1;
        r_shcnt <= r_shcnt + 4'd1;
      end
    end
  end

  // Outputs decode from state so reset cuts ROUT asynchronously.
  always_comb begin
    w_rout_vld = (r_state == SHIFT);
    w_rout     = w_rout_vld ? r_shift[SH_W-1] : ROUT_IDLE;
  end

  assign bus.ROUT     = w_rout;
  assign bus.rout_vld = w_rout_vld;
  assign bus.rd_done  = r_rd_done;
  assign bus.addr_err = r_addr_err;

endmodule

// File: tb/tb_dram_core_responder.sv
// Directed self-checking bench for dram_core_responder (default SENSE_LAT/ROUT_IDLE).
module tb_dram_core_responder;

  localparam int unsigned SENSE_LAT = 2;
  localparam logic        ROUT_IDLE = 1'b0;
`ifdef DRAM_RESP_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic CLK = 1'b0;
  logic RSTn;
  int   n_vec = 0;
  int   n_err = 0;

  dram_core_responder_if bus ();

  dram_core_responder #(
    .SENSE_LAT (SENSE_LAT),
    .ROUT_IDLE (ROUT_IDLE)
  ) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [NB-1:0] exp_word(input logic [7:0] b);
`ifdef DRAM_RESP_PARITY_EN
    return {b, ~^b};
`else
    return b;
`endif
  endfunction

  task automatic preload(input logic [5:0] row, input logic [63:0] data);
    bus.pl_wen  = 1'b1;
    bus.pl_row  = row;
    bus.pl_data = data;
    tick();
    bus.pl_wen  = 1'b0;
  endtask

  task automatic send_addr(input logic [8:0] a);
    for (int i = 8; i >= 0; i--) begin
      bus.ADVLD = 1'b1;
      bus.RAD   = a[i];
      tick();
    end
    bus.ADVLD = 1'b0;
    bus.RAD   = 1'b0;
  endtask

  // Full read; optional input noise during transfer, same-edge preload, or reset at a bit.
  task automatic do_read(input logic [8:0] a, input logic [7:0] exp_b, input bit noise,
                         input bit rbw, input logic [63:0] rbw_data, input int rst_bit,
                         input string name);
    int lat;
    bit vld_ok;
    bit quiet;
    logic [NB-1:0] got;
    send_addr(a);
    tick();
    bus.RDEN  = 1'b1;
    bus.VSAEN = 1'b1;
    tick();
    bus.RDEN  = 1'b0;
    if (noise) begin
      bus.ADVLD = 1'b1;
      bus.RDEN  = 1'b1;
      bus.RAD   = 1'b1;
    end
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (rbw && k == int'(SENSE_LAT) + 1) begin
        bus.pl_wen  = 1'b1;
        bus.pl_row  = a[8:3];
        bus.pl_data = rbw_data;
      end
      tick();
      bus.pl_wen = 1'b0;
      if (bus.rout_vld === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_vec++;
    if (lat !== int'(SENSE_LAT) + 1) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, SENSE_LAT + 1);
      bus.ADVLD = 1'b0;
      bus.RDEN  = 1'b0;
      return;
    end
    vld_ok = 1'b1;
    got    = '0;
    for (int b = 0; b < NB; b++) begin
      if (bus.rout_vld !== 1'b1 || bus.rd_done !== 1'b0) vld_ok = 1'b0;
      got = {got[NB-2:0], bus.ROUT};
      if (b == rst_bit) begin
        RSTn = 1'b0;
        #1;
        n_vec++;
        if (bus.rout_vld !== 1'b0 || bus.ROUT !== ROUT_IDLE) begin
          n_err++;
          $display("FAIL %s reset cut: rout_vld=%b ROUT=%b, expected 0/%b", name,
                   bus.rout_vld, bus.ROUT, ROUT_IDLE);
        end
        bus.ADVLD = 1'b0;
        bus.RDEN  = 1'b0;
        tick();
        tick();
        RSTn  = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 12; k++) begin
          tick();
          if (bus.rd_done !== 1'b0 || bus.rout_vld !== 1'b0) quiet = 1'b0;
        end
        n_vec++;
        if (!quiet) begin
          n_err++;
          $display("FAIL %s post-reset quiet: saw rd_done/rout_vld activity, expected none",
                   name);
        end
        return;
      end
      if (b == NB - 1) begin
        bus.ADVLD = 1'b0;
        bus.RDEN  = 1'b0;
        bus.RAD   = 1'b0;
      end
      tick();
    end
    n_vec++;
    if (got !== exp_word(exp_b) || !vld_ok) begin
      n_err++;
      $display("FAIL %s data: got %h (vld_ok=%b), expected %h", name, got, vld_ok,
               exp_word(exp_b));
    end
    n_vec++;
    if (bus.rd_done !== 1'b1 || bus.rout_vld !== 1'b0 || bus.ROUT !== ROUT_IDLE) begin
      n_err++;
      $display("FAIL %s done: rd_done=%b rout_vld=%b ROUT=%b, expected 1/0/%b", name,
               bus.rd_done, bus.rout_vld, bus.ROUT, ROUT_IDLE);
    end
    tick();
    n_vec++;
    if (bus.rd_done !== 1'b0) begin
      n_err++;
      $display("FAIL %s done width: rd_done=%b after one cycle, expected 0", name,
               bus.rd_done);
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    tick();
    tick();
    n_vec++;
    if (bus.ROUT !== ROUT_IDLE) begin
      n_err++;
      $display("FAIL reset ROUT: got %b, expected %b", bus.ROUT, ROUT_IDLE);
    end
    n_vec++;
    if (bus.rout_vld !== 1'b0) begin
      n_err++;
      $display("FAIL reset rout_vld: got %b, expected 0", bus.rout_vld);
    end
    n_vec++;
    if (bus.rd_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset rd_done: got %b, expected 0", bus.rd_done);
    end
    n_vec++;
    if (bus.addr_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset addr_err: got %b, expected 0", bus.addr_err);
    end
    RSTn = 1'b1;
    tick();
  endtask

  task automatic test_basic_read();
    preload(6'd5, 64'h0123_4567_89AB_CDEF);
    preload(6'd63, 64'h8000_0000_0000_0001);
    do_read(9'b000101_010, 8'hAB, 1'b0, 1'b0, '0, -1, "basic_ab");
    do_read(9'b000101_000, 8'hEF, 1'b0, 1'b0, '0, -1, "byte0");
    do_read(9'b111111_111, 8'h80, 1'b0, 1'b0, '0, -1, "row63_byte7");
  endtask

  task automatic test_ignore_inputs();
    do_read(9'b111111_000, 8'h01, 1'b1, 1'b0, '0, -1, "noise_ignored");
  endtask

  task automatic test_short_addr();
    bit quiet;
    for (int i = 0; i < 7; i++) begin
      bus.ADVLD = 1'b1;
      bus.RAD   = 1'b1;
      tick();
    end
    bus.ADVLD = 1'b0;
    tick();
    n_vec++;
    if (bus.addr_err !== 1'b1) begin
      n_err++;
      $display("FAIL short_addr err: addr_err=%b, expected 1", bus.addr_err);
    end
    tick();
    n_vec++;
    if (bus.addr_err !== 1'b0) begin
      n_err++;
      $display("FAIL short_addr pulse: addr_err=%b, expected 0", bus.addr_err);
    end
    bus.RDEN = 1'b1;
    quiet    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.rout_vld !== 1'b0) quiet = 1'b0;
    end
    bus.RDEN = 1'b0;
    n_vec++;
    if (!quiet) begin
      n_err++;
      $display("FAIL short_addr rden: rout_vld seen high, expected 0");
    end
    tick();
  endtask

  task automatic test_long_addr();
    for (int i = 0; i < 10; i++) begin
      bus.ADVLD = 1'b1;
      bus.RAD   = 1'b0;
      tick();
    end
    n_vec++;
    if (bus.addr_err !== 1'b0) begin
      n_err++;
      $display("FAIL long_addr early: addr_err=%b while ADVLD high, expected 0",
               bus.addr_err);
    end
    bus.ADVLD = 1'b0;
    tick();
    n_vec++;
    if (bus.addr_err !== 1'b1) begin
      n_err++;
      $display("FAIL long_addr err: addr_err=%b, expected 1", bus.addr_err);
    end
    tick();
  endtask

  task automatic test_sense_miss();
    bit ok;
    send_addr(9'b000101_010);
    tick();
    bus.RDEN  = 1'b1;
    bus.VSAEN = 1'b0;
    tick();
    bus.RDEN = 1'b0;
    ok = 1'b1;
    for (int k = 1; k <= int'(SENSE_LAT); k++) begin
      tick();
      if (bus.addr_err !== 1'b0 || bus.rout_vld !== 1'b0 || bus.ROUT !== ROUT_IDLE) ok = 1'b0;
    end
    tick();
    n_vec++;
    if (bus.addr_err !== 1'b1 || !ok) begin
      n_err++;
      $display("FAIL sense_miss err: addr_err=%b ok=%b, expected 1/1", bus.addr_err, ok);
    end
    n_vec++;
    if (bus.rout_vld !== 1'b0 || bus.ROUT !== ROUT_IDLE) begin
      n_err++;
      $display("FAIL sense_miss rout: rout_vld=%b ROUT=%b, expected 0/%b", bus.rout_vld,
               bus.ROUT, ROUT_IDLE);
    end
    bus.VSAEN = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_shift();
    do_read(9'b000101_010, 8'hAB, 1'b0, 1'b0, '0, 3, "rst_mid_shift");
    do_read(9'b000101_010, 8'hAB, 1'b0, 1'b0, '0, -1, "after_reset");
  endtask

  task automatic test_read_before_write();
    do_read(9'b000101_010, 8'hAB, 1'b0, 1'b1, 64'hFEDC_BA98_7654_3210, -1, "rbw_old");
    do_read(9'b000101_010, 8'h54, 1'b0, 1'b0, '0, -1, "rbw_new");
    do_read(9'b000101_111, 8'hFE, 1'b0, 1'b0, '0, -1, "new_byte7");
  endtask

  task automatic test_armed_restart();
    send_addr(9'b111111_111);
    tick();
    do_read(9'b000101_001, 8'h32, 1'b0, 1'b0, '0, -1, "armed_restart");
  endtask

  initial begin
    RSTn        = 1'b0;
    bus.RAD     = 1'b0;
    bus.ADVLD   = 1'b0;
    bus.RDEN    = 1'b0;
    bus.VSAEN   = 1'b1;
    bus.pl_wen  = 1'b0;
    bus.pl_row  = '0;
    bus.pl_data = '0;
    test_reset();
    test_basic_read();
    test_ignore_inputs();
    test_short_addr();
    test_long_addr();
    test_sense_miss();
    test_reset_mid_shift();
    test_read_before_write();
    test_armed_restart();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
